// File: rtl/mux_scan_sequencer.sv
// Drives a 16:1 mux through channels 0..15, waits SETTLE cycles per channel,
// samples the mux output and publishes the 16 bits as one word with a valid strobe.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic [15:0] word,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [14:0] shadow_q, shadow_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        if (sel_q != 4'hF) begin
          shadow_d[sel_q] = mux_out;
          sel_d           = sel_q + 4'd1;
          state_d         = S_SETTLE;
        end else begin
          // Channel 15 goes straight into the word, so the shadow only holds 0..14.
          word_d  = {mux_out, shadow_q};
          valid_d = 1'b1;
          sel_d   = '0;
          if (cont) begin
            state_d = S_SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel   = sel_q;
  assign word  = word_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: SETTLE=1 and SETTLE=3 instances,
// each fronted by a behavioural 16:1 mux over a data word.
module tb_mux_scan_sequencer;

  localparam int unsigned P1 = 1;
  localparam int unsigned P3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start1, cont1, mux1, valid1, busy1;
  logic [15:0] data1, word1;
  logic [3:0]  sel1;

  logic        start3, cont3, mux3, valid3, busy3;
  logic [15:0] data3, word3;
  logic [3:0]  sel3;

  assign mux1 = data1[sel1];
  assign mux3 = data3[sel3];

  mux_scan_sequencer #(.SETTLE(P1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .mux_out(mux1),
    .sel(sel1), .word(word1), .valid(valid1), .busy(busy1)
  );

  mux_scan_sequencer #(.SETTLE(P3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cont(cont3), .mux_out(mux3),
    .sel(sel3), .word(word3), .valid(valid3), .busy(busy3)
  );

  int checks = 0;
  int passes = 0;
  logic [15:0] exp1[$];
  logic [15:0] exp3[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start1 = 1'b1;
    start3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({sel1, word1, valid1, busy1} !== 22'h0)
        $display("FAIL reset_dut1: got sel=%h word=%h valid=%b busy=%b expected all zero",
                 sel1, word1, valid1, busy1);
      else passes++;
      checks++;
      if ({sel3, word3, valid3, busy3} !== 22'h0)
        $display("FAIL reset_dut3: got sel=%h word=%h valid=%b busy=%b expected all zero",
                 sel3, word3, valid3, busy3);
      else passes++;
    end
    start1 = 1'b0;
    start3 = 1'b0;
    rst_n  = 1'b1;
    step();
  endtask

  // One-shot scan on the SETTLE=1 instance; optionally pulses start when sel hits pulse_sel.
  task automatic scan1(input logic [15:0] d, input int pulse_sel);
    int n;
    bit pulsed;
    logic [15:0] e;
    data1  = d;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    exp1.push_back(d);
    checks++;
    if (busy1 !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy1);
    else passes++;
    n = 0;
    pulsed = 1'b0;
    while (n < 200) begin
      step();
      n++;
      if (start1) start1 = 1'b0;
      if (valid1) break;
      if (pulse_sel >= 0 && !pulsed && sel1 == pulse_sel[3:0]) begin
        start1 = 1'b1;
        pulsed = 1'b1;
      end
    end
    start1 = 1'b0;
    checks++;
    if (n != 16 * (P1 + 1)) $display("FAIL valid_latency: got %0d expected %0d", n, 16 * (P1 + 1));
    else passes++;
    e = exp1.pop_front();
    checks++;
    if (word1 !== e) $display("FAIL word1: got %h expected %h", word1, e);
    else passes++;
    checks++;
    if (busy1 !== 1'b0) $display("FAIL busy_fall: got %b expected 0", busy1);
    else passes++;
    step();
    checks++;
    if (valid1 !== 1'b0) $display("FAIL valid_one_cycle: got %b expected 0", valid1);
    else passes++;
  endtask

  task automatic wait3(output int n);
    n = 0;
    while (n < 300) begin
      step();
      n++;
      if (valid3) break;
    end
  endtask

  task automatic test_single();
    scan1(16'hA5C3, -1);
  endtask

  task automatic test_onehot();
    logic [15:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 16'h0001 << i;
      scan1(d, -1);
    end
  endtask

  task automatic test_continuous();
    int n, seen;
    logic [15:0] e;
    data3  = 16'h00FF;
    cont3  = 1'b1;
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    exp3.push_back(16'h00FF);
    wait3(n);
    checks++;
    if (n != 16 * (P3 + 1)) $display("FAIL cont_period1: got %0d expected %0d", n, 16 * (P3 + 1));
    else passes++;
    e = exp3.pop_front();
    checks++;
    if (word3 !== e) $display("FAIL cont_word1: got %h expected %h", word3, e);
    else passes++;
    checks++;
    if (busy3 !== 1'b1) $display("FAIL cont_busy1: got %b expected 1", busy3);
    else passes++;

    data3 = 16'hFF00;
    exp3.push_back(16'hFF00);
    wait3(n);
    checks++;
    if (n != 16 * (P3 + 1)) $display("FAIL cont_period2: got %0d expected %0d", n, 16 * (P3 + 1));
    else passes++;
    e = exp3.pop_front();
    checks++;
    if (word3 !== e) $display("FAIL cont_word2: got %h expected %h", word3, e);
    else passes++;
    checks++;
    if (busy3 !== 1'b1) $display("FAIL cont_busy2: got %b expected 1", busy3);
    else passes++;

    // Drop cont part-way through the third scan.
    data3 = 16'h3C5A;
    exp3.push_back(16'h3C5A);
    repeat (20) step();
    cont3 = 1'b0;
    wait3(n);
    checks++;
    if (n != 16 * (P3 + 1) - 20) $display("FAIL cont_period3: got %0d expected %0d", n, 16 * (P3 + 1) - 20);
    else passes++;
    e = exp3.pop_front();
    checks++;
    if (word3 !== e) $display("FAIL cont_word3: got %h expected %h", word3, e);
    else passes++;
    checks++;
    if (busy3 !== 1'b0) $display("FAIL cont_stop_busy: got %b expected 0", busy3);
    else passes++;
    seen = 0;
    repeat (100) begin
      step();
      if (valid3 || busy3) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL cont_idle: got %0d active cycles expected 0", seen);
    else passes++;
  endtask

  task automatic test_start_while_busy();
    scan1(16'h3C96, 7);
  endtask

  task automatic test_reset_mid();
    int n, seen;
    data1  = 16'hFFFF;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    exp1.push_back(16'hFFFF);
    n = 0;
    while (n < 200) begin
      step();
      n++;
      if (sel1 == 4'd9) break;
    end
    checks++;
    if (sel1 !== 4'd9) $display("FAIL reach_sel9: got %h expected 9", sel1);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sel1, word1, valid1, busy1} !== 22'h0)
      $display("FAIL async_reset: got sel=%h word=%h valid=%b busy=%b expected all zero",
               sel1, word1, valid1, busy1);
    else passes++;
    exp1.delete();
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      step();
      if (valid1 || busy1 || word1 != 16'h0) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL post_reset_quiet: got %0d active cycles expected 0", seen);
    else passes++;
    scan1(16'h5A3C, -1);
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    cont1  = 1'b0;
    data1  = '0;
    start3 = 1'b0;
    cont3  = 1'b0;
    data3  = '0;
    test_reset();
    test_single();
    test_onehot();
    test_continuous();
    test_start_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
